// File: rtl/led_ctrl_pkg.sv
// Shared types and register map for the memory-mapped LED controller.
package led_ctrl_pkg;

  // Per-channel output mode, two bits per channel in the MODE register.
  typedef enum logic [1:0] {
    ModeStatic = 2'b00,
    ModeBlink  = 2'b01,
    ModePwm    = 2'b10,
    ModeOff    = 2'b11
  } led_mode_e;

  // Word offsets inside the 16-byte register window (bus_addr[3:2]).
  localparam logic [1:0] REG_DATA  = 2'd0;
  localparam logic [1:0] REG_MODE  = 2'd1;
  localparam logic [1:0] REG_PRESC = 2'd2;
  localparam logic [1:0] REG_DUTY  = 2'd3;

endpackage

// File: rtl/led_tick_gen.sv
// Programmable prescaler: emits a registered one-cycle tick every presc+1 cycles.
module led_tick_gen #(
  parameter int unsigned PRESC_W = 24
) (
  input  logic               clk,
  input  logic               sys_rst_n,
  input  logic [PRESC_W-1:0] presc,
  input  logic               clr,
  output logic               tick
);

  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic               tick_q, tick_d;

  // Count 0..presc; a clear restarts the period and suppresses the pending tick.
  always_comb begin
    pcnt_d = pcnt_q + PRESC_W'(1);
    tick_d = 1'b0;
    if (clr) begin
      pcnt_d = '0;
    end else if (pcnt_q == presc) begin
      pcnt_d = '0;
      tick_d = 1'b1;
    end
  end

  // Prescaler state, discarded immediately on reset.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/mmio_led_ctrl.sv
// Memory-mapped LED controller: register file, address decode, blink/PWM timing
// and registered pin drive for N_LED channels.
module mmio_led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned N_LED      = 6,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0010,
  parameter int unsigned PRESC_W    = 24,
  parameter int unsigned PWM_W      = 8,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             sys_rst_n,
  input  logic [31:0]      bus_addr,
  input  logic [31:0]      bus_wdata,
  input  logic             bus_we,
  output logic [31:0]      bus_rdata,
  output logic [N_LED-1:0] led,
  output logic             tick
);

  logic [N_LED-1:0]   data_q, data_d;
  logic [2*N_LED-1:0] mode_q, mode_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PWM_W-1:0]   duty_q, duty_d;
  logic [PWM_W-1:0]   wcnt_q, wcnt_d;
  logic               phase_q, phase_d;
  logic [N_LED-1:0]   led_q, led_d;

  logic               hit;
  logic [1:0]         offset;
  logic               wr_en;
  logic               presc_wr;
  logic               pwm_on;
  logic [N_LED-1:0]   state;

  // Byte lanes and upper store bits beyond each register width are not used.
  logic unused_bits;
  assign unused_bits = ^{bus_addr[1:0], bus_wdata};

  assign hit      = (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign offset   = bus_addr[3:2];
  assign wr_en    = bus_we && hit;
  assign presc_wr = wr_en && (offset == REG_PRESC);

  led_tick_gen #(
    .PRESC_W (PRESC_W)
  ) u_tick_gen (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .presc     (presc_q),
    .clr       (presc_wr),
    .tick      (tick)
  );

  // Register file next-state: a decoded store replaces the addressed register.
  always_comb begin
    data_d  = data_q;
    mode_d  = mode_q;
    presc_d = presc_q;
    duty_d  = duty_q;
    if (wr_en) begin
      unique case (offset)
        REG_DATA:  data_d  = bus_wdata[N_LED-1:0];
        REG_MODE:  mode_d  = bus_wdata[2*N_LED-1:0];
        REG_PRESC: presc_d = bus_wdata[PRESC_W-1:0];
        REG_DUTY:  duty_d  = bus_wdata[PWM_W-1:0];
        default:   ;
      endcase
    end
  end

  // Combinational readback; shows pre-store contents during a store cycle.
  always_comb begin
    bus_rdata = '0;
    if (hit) begin
      unique case (offset)
        REG_DATA:  bus_rdata[N_LED-1:0]   = data_q;
        REG_MODE:  bus_rdata[2*N_LED-1:0] = mode_q;
        REG_PRESC: bus_rdata[PRESC_W-1:0] = presc_q;
        REG_DUTY:  bus_rdata[PWM_W-1:0]   = duty_q;
        default:   bus_rdata = '0;
      endcase
    end
  end

  // Blink phase and PWM counter advance on tick; a PRESC store realigns the phase.
  always_comb begin
    phase_d = phase_q;
    wcnt_d  = wcnt_q;
    if (presc_wr) begin
      phase_d = 1'b0;
    end else if (tick) begin
      phase_d = ~phase_q;
    end
    if (tick) begin
      wcnt_d = wcnt_q + PWM_W'(1);
    end
  end

  // Per-channel mode mux and pin polarity.
  always_comb begin
    pwm_on = (wcnt_q < duty_q);
    state  = '0;
    for (int unsigned i = 0; i < N_LED; i++) begin
      unique case (led_mode_e'(mode_q[2*i +: 2]))
        ModeStatic: state[i] = data_q[i];
        ModeBlink:  state[i] = data_q[i] & phase_q;
        ModePwm:    state[i] = pwm_on;
        ModeOff:    state[i] = 1'b0;
        default:    state[i] = 1'b0;
      endcase
    end
    led_d = state ^ {N_LED{ACTIVE_LOW}};
  end

  // All state; reset leaves every pin dark.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data_q  <= '0;
      mode_q  <= '0;
      presc_q <= '0;
      duty_q  <= '0;
      wcnt_q  <= '0;
      phase_q <= 1'b0;
      led_q   <= {N_LED{ACTIVE_LOW}};
    end else begin
      data_q  <= data_d;
      mode_q  <= mode_d;
      presc_q <= presc_d;
      duty_q  <= duty_d;
      wcnt_q  <= wcnt_d;
      phase_q <= phase_d;
      led_q   <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_mmio_led_ctrl.sv
// Scoreboard bench for mmio_led_ctrl: stimulus queues cycle-tagged expectations,
// a negedge monitor compares them against the DUT outputs.
module tb_mmio_led_ctrl;

  localparam int unsigned NLed = 6;
  localparam logic [31:0] Base = 32'h0000_0010;

  localparam int KLed   = 0;
  localparam int KRdata = 1;
  localparam int KTick  = 2;
  localparam int KMark  = 3;
  localparam int KLit   = 4;

  typedef struct {
    int          kind;
    string       name;
    logic [31:0] exp;
    int          due;
  } exp_t;

  logic            clk = 1'b0;
  logic            sys_rst_n = 1'b0;
  logic [31:0]     bus_addr = '0;
  logic [31:0]     bus_wdata = '0;
  logic            bus_we = 1'b0;
  logic [31:0]     bus_rdata;
  logic [NLed-1:0] led;
  logic            tick;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int lit_cnt = 0;
  int lit_base = 0;

  exp_t        sb[$];
  exp_t        keep[$];
  logic [31:0] act;

  mmio_led_ctrl #(
    .N_LED      (NLed),
    .BASE_ADDR  (Base),
    .PRESC_W    (24),
    .PWM_W      (8),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_rdata (bus_rdata),
    .led       (led),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  initial begin : cycle_count
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: at each negedge pop every expectation due this cycle and compare.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (led[2] == 1'b0) lit_cnt++;
      keep = {};
      foreach (sb[j]) begin
        if (sb[j].due != cyc) begin
          keep.push_back(sb[j]);
        end else if (sb[j].kind == KMark) begin
          lit_base = lit_cnt;
        end else begin
          case (sb[j].kind)
            KLed:    act = 32'(led);
            KRdata:  act = bus_rdata;
            KTick:   act = {31'd0, tick};
            default: act = 32'(lit_cnt - lit_base);
          endcase
          total++;
          if (act !== sb[j].exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", sb[j].name, cyc, act, sb[j].exp);
          end
        end
      end
      sb = keep;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish, pending=%0d", sb.size());
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic expect_at(input int kind, input string name, input logic [31:0] exp,
                           input int due);
    exp_t e;
    e.kind = kind;
    e.name = name;
    e.exp  = exp;
    e.due  = due;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    step();
    bus_we    = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    bus_addr = a;
    expect_at(KRdata, name, exp, cyc);
    step();
  endtask

  initial begin : stim
    int a, p, d, q, w, r, s;

    // Reset: pins dark, tick low while held; then tick every cycle with PRESC=0.
    step();
    step();
    total++;
    if (led !== 6'h3f) begin
      bad++;
      $display("FAIL direct_rst_led got=0x%0h", led);
    end
    expect_at(KLed, "rst_led", 32'h3f, cyc);
    expect_at(KTick, "rst_tick", 32'h0, cyc);
    step();
    sys_rst_n = 1'b1;
    expect_at(KTick, "tick_after_rst", 32'h0, cyc);
    for (int i = 1; i <= 4; i++) expect_at(KTick, "tick_presc0", 32'h1, cyc + i);
    rd(Base + 32'h0, 32'h0, "rst_data");
    rd(Base + 32'h4, 32'h0, "rst_mode");
    rd(Base + 32'h8, 32'h0, "rst_presc");
    rd(Base + 32'hc, 32'h0, "rst_duty");

    // Static: read during the store returns the old value; pins follow one edge later.
    bus_addr  = Base;
    bus_wdata = 32'h15;
    bus_we    = 1'b1;
    expect_at(KRdata, "rd_during_wr", 32'h0, cyc);
    step();
    bus_we = 1'b0;
    expect_at(KLed, "static_old", 32'h3f, cyc);
    expect_at(KLed, "static_new", 32'h2a, cyc + 1);
    step();
    rd(Base + 32'h0, 32'h15, "rd_data");
    rd(Base + 32'h3, 32'h15, "rd_data_lane");
    total++;
    if (bus_rdata !== 32'h15) begin
      bad++;
      $display("FAIL direct_rd_data got=0x%0h", bus_rdata);
    end

    // Decode: stores just outside the window are ignored and read as zero.
    wr(Base + 32'h10, 32'h3f);
    wr(Base - 32'h4, 32'h3f);
    expect_at(KLed, "decode_led", 32'h2a, cyc + 1);
    rd(Base + 32'h10, 32'h0, "rd_above");
    rd(Base - 32'h4, 32'h0, "rd_below");
    rd(Base + 32'h0, 32'h15, "rd_data_kept");
    total++;
    if (bus_rdata !== 32'h15) begin
      bad++;
      $display("FAIL direct_rd_data_kept got=0x%0h", bus_rdata);
    end

    // Truncation of an oversized store.
    wr(Base + 32'hc, 32'h0000_01ff);
    rd(Base + 32'hc, 32'hff, "duty_trunc");
    total++;
    if (bus_rdata !== 32'hff) begin
      bad++;
      $display("FAIL direct_duty_trunc got=0x%0h", bus_rdata);
    end

    // Blink: PRESC=3, channel 0 blinking.
    wr(Base + 32'h8, 32'd3);
    a = cyc;
    for (int n = 1; n <= 16; n++) begin
      expect_at(KTick, "blink_tick", (n % 4 == 0) ? 32'h1 : 32'h0, a + n);
    end
    for (int n = 3; n <= 17; n++) begin
      expect_at(KLed, "blink_led", (((n - 2) / 4) % 2 == 1) ? 32'h3e : 32'h3f, a + n);
    end
    wr(Base + 32'h0, 32'h01);
    wr(Base + 32'h4, 32'h1);
    step_to(a + 18);

    // PWM: DUTY=64 on channel 2 lights 64 of every 256 cycles; DUTY=0 never.
    wr(Base + 32'hc, 32'd64);
    wr(Base + 32'h4, 32'h20);
    wr(Base + 32'h8, 32'd0);
    p = cyc;
    s = p + 5;
    expect_at(KMark, "mark", 32'h0, s);
    expect_at(KLit, "pwm_lit64", 32'd64, s + 256);
    step_to(s + 257);
    wr(Base + 32'hc, 32'd0);
    d = cyc;
    expect_at(KMark, "mark", 32'h0, d + 1);
    expect_at(KLed, "pwm_duty0_led", 32'h3e, d + 2);
    expect_at(KLed, "pwm_duty0_led", 32'h3e, d + 200);
    expect_at(KLit, "pwm_lit0", 32'd0, d + 257);
    step_to(d + 258);

    // PRESC rewrite below the running count: next tick 11 cycles after the store edge.
    wr(Base + 32'h8, 32'd100);
    q = cyc;
    expect_at(KTick, "presc100_quiet", 32'h0, q);
    expect_at(KTick, "presc100_quiet", 32'h0, q + 20);
    expect_at(KTick, "presc100_quiet", 32'h0, q + 49);
    step_to(q + 50);
    wr(Base + 32'h8, 32'd10);
    w = cyc;
    for (int n = 0; n <= 10; n++) expect_at(KTick, "rewrite_no_tick", 32'h0, w + n);
    expect_at(KTick, "rewrite_tick", 32'h1, w + 11);
    step_to(w + 12);

    // Async reset mid-blink: lit pin goes dark without a clock edge.
    wr(Base + 32'h4, 32'h1);
    wr(Base + 32'h8, 32'd1);
    r = cyc;
    expect_at(KLed, "pre_rst_lit", 32'h3e, r + 4);
    step_to(r + 5);
    sys_rst_n = 1'b0;
    bus_addr  = Base + 32'h8;
    expect_at(KLed, "async_rst_led", 32'h3f, cyc);
    expect_at(KTick, "async_rst_tick", 32'h0, cyc);
    expect_at(KRdata, "async_rst_presc", 32'h0, cyc);
    step();
    sys_rst_n = 1'b1;
    total++;
    if (led !== 6'h3f) begin
      bad++;
      $display("FAIL direct_post_rst_led got=0x%0h", led);
    end
    expect_at(KLed, "post_rst_led", 32'h3f, cyc + 2);
    step_to(cyc + 4);

    foreach (sb[j]) begin
      total++;
      bad++;
      $display("FAIL %s never checked: due=%0d now=%0d", sb[j].name, sb[j].due, cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
